mem_wb_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline interface. Takes the Mem_* bundle, performs the data-memory access and resolves the branch decision.
- Captures the write-back bundle into the MEM/WB pipeline register.
- Holds the data memory array. Drives PC redirect toward IF and the Wb_* bundle toward the register file.

---
 rtl/mem_wb_stage.sv | 142 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: data-memory access with sub-word
// lanes, branch resolution and write-back capture, all clocked on the falling edge.
module mem_wb_stage #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Mem_branch_addr,
    input  logic [31:0] Mem_npc,
    input  logic [31:0] Mem_ALUout,
    input  logic [31:0] Mem_datain,
    input  logic [4:0]  Mem_Rw,
    input  logic        Mem_MemWr,
    input  logic [2:0]  Mem_Branch,
    input  logic        Mem_Zero,
    input  logic        Mem_Sign,
    input  logic [2:0]  Mem_ExtOp3,
    input  logic [1:0]  Mem_MemtoReg,
    input  logic        Mem_RegWr,
    output logic        Mem_PCSrc,
    output logic [31:0] Mem_target,
    output logic [31:0] Wb_wdata,
    output logic [4:0]  Wb_Rw,
    output logic        Wb_RegWr,
    output logic [1:0]  Wb_MemtoReg
);

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [3:0]    byte_en;
    logic [31:0]   store_lanes;
    logic [31:0]   merged_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic          taken;

    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [4:0]  wb_rw_q, wb_rw_d;
    logic        wb_regwr_q, wb_regwr_d;
    logic [1:0]  wb_memtoreg_q, wb_memtoreg_d;

    assign word_idx = Mem_ALUout[AW+1:2];
    assign lane     = Mem_ALUout[1:0];
    assign rd_word  = mem_q[word_idx];

    always_comb begin
        taken = 1'b0;
        case (Mem_Branch)
            3'b000: taken = 1'b0;
            3'b001: taken = Mem_Zero;
            3'b010: taken = ~Mem_Zero;
            3'b011: taken = ~Mem_Sign;
            3'b100: taken = ~Mem_Sign & ~Mem_Zero;
            3'b101: taken = Mem_Sign | Mem_Zero;
            3'b110: taken = Mem_Sign;
            default: taken = 1'b1;
        endcase
    end

    assign Mem_PCSrc  = taken & ~rst;
    assign Mem_target = Mem_branch_addr;

    // Store data is replicated across lanes so the merge only needs byte enables.
    always_comb begin
        byte_en     = 4'b1111;
        store_lanes = Mem_datain;
        case (Mem_ExtOp3)
            3'b001, 3'b010: begin
                byte_en     = 4'b0001 << lane;
                store_lanes = {4{Mem_datain[7:0]}};
            end
            3'b011, 3'b100: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{Mem_datain[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_word[gi*8 +: 8] = byte_en[gi] ? store_lanes[gi*8 +: 8]
                                                    : rd_word[gi*8 +: 8];
    end

    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_ext = rd_word;
        case (Mem_ExtOp3)
            3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_ext = {24'd0, ld_byte};
            3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {16'd0, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    always_comb begin
        wb_wdata_d    = Mem_ALUout;
        wb_rw_d       = Mem_Rw;
        wb_regwr_d    = Mem_RegWr & (Mem_Rw != 5'd0);
        wb_memtoreg_d = Mem_MemtoReg;
        case (Mem_MemtoReg)
            2'b01:   wb_wdata_d = ld_ext;
            2'b10:   wb_wdata_d = Mem_npc;
            default: wb_wdata_d = Mem_ALUout;
        endcase
    end

    // Memory contents deliberately survive reset; only the write is gated.
    always_ff @(negedge clk) begin
        if (!rst && Mem_MemWr) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            wb_wdata_q    <= 32'd0;
            wb_rw_q       <= 5'd0;
            wb_regwr_q    <= 1'b0;
            wb_memtoreg_q <= 2'b00;
        end else begin
            wb_wdata_q    <= wb_wdata_d;
            wb_rw_q       <= wb_rw_d;
            wb_regwr_q    <= wb_regwr_d;
            wb_memtoreg_q <= wb_memtoreg_d;
        end
    end

    assign Wb_wdata    = wb_wdata_q;
    assign Wb_Rw       = wb_rw_q;
    assign Wb_RegWr    = wb_regwr_q;
    assign Wb_MemtoReg = wb_memtoreg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: memory access, sub-word lanes,
// branch matrix, link/$0 handling, mid-stream reset and address wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b1;
    logic        rst;
    logic [31:0] Mem_branch_addr, Mem_npc, Mem_ALUout, Mem_datain;
    logic [4:0]  Mem_Rw;
    logic        Mem_MemWr, Mem_Zero, Mem_Sign, Mem_RegWr;
    logic [2:0]  Mem_Branch, Mem_ExtOp3;
    logic [1:0]  Mem_MemtoReg;
    logic        Mem_PCSrc;
    logic [31:0] Mem_target, Wb_wdata;
    logic [4:0]  Wb_Rw;
    logic        Wb_RegWr;
    logic [1:0]  Wb_MemtoReg;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DEPTH(1024), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .Mem_branch_addr(Mem_branch_addr), .Mem_npc(Mem_npc),
        .Mem_ALUout(Mem_ALUout), .Mem_datain(Mem_datain),
        .Mem_Rw(Mem_Rw), .Mem_MemWr(Mem_MemWr), .Mem_Branch(Mem_Branch),
        .Mem_Zero(Mem_Zero), .Mem_Sign(Mem_Sign), .Mem_ExtOp3(Mem_ExtOp3),
        .Mem_MemtoReg(Mem_MemtoReg), .Mem_RegWr(Mem_RegWr),
        .Mem_PCSrc(Mem_PCSrc), .Mem_target(Mem_target),
        .Wb_wdata(Wb_wdata), .Wb_Rw(Wb_Rw), .Wb_RegWr(Wb_RegWr),
        .Wb_MemtoReg(Wb_MemtoReg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] din, input logic wr,
                         input logic [2:0] ext, input logic [1:0] mtr,
                         input logic [4:0] rw, input logic rwr);
        Mem_ALUout   = alu;
        Mem_datain   = din;
        Mem_MemWr    = wr;
        Mem_ExtOp3   = ext;
        Mem_MemtoReg = mtr;
        Mem_Rw       = rw;
        Mem_RegWr    = rwr;
        Mem_Branch   = 3'b000;
    endtask

    task automatic store(input logic [31:0] alu, input logic [31:0] din, input logic [2:0] ext);
        drive(alu, din, 1'b1, ext, 2'b00, 5'd0, 1'b0);
        cycle();
    endtask

    task automatic load(input string tag, input logic [31:0] alu, input logic [2:0] ext,
                        input logic [31:0] exp);
        drive(alu, 32'd0, 1'b0, ext, 2'b01, 5'd9, 1'b1);
        cycle();
        check(tag, Wb_wdata, exp);
    endtask

    function automatic logic exp_taken(input logic [2:0] br, input logic z, input logic s);
        case (br)
            3'b001:  return z;
            3'b010:  return !z;
            3'b011:  return !s;
            3'b100:  return !s && !z;
            3'b101:  return s || z;
            3'b110:  return s;
            3'b111:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        Mem_branch_addr = 32'h0040_1000;
        Mem_npc  = 32'd0;
        Mem_Zero = 1'b0;
        Mem_Sign = 1'b0;
        drive(32'h10, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'b10, 5'd7, 1'b1);
        Mem_Branch = 3'b111;
        cycle();
        cycle();
        check("rst_wdata", Wb_wdata, 32'd0);
        check("rst_rw", {27'd0, Wb_Rw}, 32'd0);
        check("rst_regwr", {31'd0, Wb_RegWr}, 32'd0);
        check("rst_mtr", {30'd0, Wb_MemtoReg}, 32'd0);
        check("rst_pcsrc", {31'd0, Mem_PCSrc}, 32'd0);
        rst = 1'b0;

        // Word store then load
        store(32'h10, 32'hDEAD_BEEF, 3'b000);
        drive(32'h10, 32'd0, 1'b0, 3'b000, 2'b01, 5'd8, 1'b1);
        cycle();
        check("lw_data", Wb_wdata, 32'hDEAD_BEEF);
        check("lw_rw", {27'd0, Wb_Rw}, 32'd8);
        check("lw_regwr", {31'd0, Wb_RegWr}, 32'd1);
        check("lw_mtr", {30'd0, Wb_MemtoReg}, 32'd1);

        // Sub-word lanes
        store(32'h20, 32'h1234_5678, 3'b000);
        store(32'h21, 32'h1234_56AA, 3'b001);
        load("sb_word", 32'h20, 3'b000, 32'h1234_AA78);
        load("lb_21", 32'h21, 3'b001, 32'hFFFF_FFAA);
        load("lbu_21", 32'h21, 3'b010, 32'h0000_00AA);
        load("lb_20", 32'h20, 3'b001, 32'h0000_0078);
        load("lh_22", 32'h22, 3'b011, 32'h0000_1234);
        load("lh_23_align", 32'h23, 3'b011, 32'h0000_1234);
        store(32'h22, 32'hFFFF_8001, 3'b011);
        load("lhu_22", 32'h22, 3'b100, 32'h0000_8001);
        load("lh_22_neg", 32'h22, 3'b011, 32'hFFFF_8001);
        load("sh_word", 32'h20, 3'b000, 32'h8001_AA78);
        load("lbu_23", 32'h23, 3'b010, 32'h0000_0080);
        load("lw_misalign", 32'h23, 3'b111, 32'h8001_AA78);
        store(32'h24, 32'hCAFE_0001, 3'b110);
        load("ext110_word", 32'h24, 3'b000, 32'hCAFE_0001);

        // Write-back source for MemtoReg 00 / 11
        drive(32'h0000_ABCD, 32'd0, 1'b0, 3'b000, 2'b00, 5'd3, 1'b1);
        cycle();
        check("mtr00_alu", Wb_wdata, 32'h0000_ABCD);
        drive(32'h0000_1357, 32'd0, 1'b0, 3'b000, 2'b11, 5'd3, 1'b1);
        cycle();
        check("mtr11_alu", Wb_wdata, 32'h0000_1357);

        // Branch matrix
        for (int b = 0; b < 8; b++) begin
            for (int zs = 0; zs < 4; zs++) begin
                Mem_Branch      = 3'(b);
                Mem_Zero        = zs[0];
                Mem_Sign        = zs[1];
                Mem_branch_addr = 32'h0040_0000 + 32'(b * 16 + zs * 4);
                #1;
                check($sformatf("br%0d_z%0d_s%0d", b, zs & 1, zs >> 1),
                      {31'd0, Mem_PCSrc}, {31'd0, exp_taken(3'(b), zs[0], zs[1])});
            end
            check($sformatf("target_br%0d", b), Mem_target, 32'h0040_000C + 32'(b * 16));
        end
        Mem_Zero = 1'b0;
        Mem_Sign = 1'b0;

        // Link and $0
        drive(32'h0, 32'd0, 1'b0, 3'b000, 2'b10, 5'd31, 1'b1);
        Mem_Branch = 3'b111;
        Mem_npc    = 32'h0040_000C;
        #1;
        check("jal_pcsrc", {31'd0, Mem_PCSrc}, 32'd1);
        cycle();
        check("jal_wdata", Wb_wdata, 32'h0040_000C);
        check("jal_rw", {27'd0, Wb_Rw}, 32'd31);
        check("jal_regwr", {31'd0, Wb_RegWr}, 32'd1);
        Mem_Rw = 5'd0;
        cycle();
        check("r0_regwr", {31'd0, Wb_RegWr}, 32'd0);

        // Reset mid-operation
        store(32'h40, 32'hCAFE_F00D, 3'b000);
        drive(32'h40, 32'h0000_0055, 1'b1, 3'b000, 2'b10, 5'd5, 1'b1);
        Mem_Branch = 3'b111;
        rst = 1'b1;
        #1;
        check("midrst_pcsrc", {31'd0, Mem_PCSrc}, 32'd0);
        cycle();
        check("midrst_wdata", Wb_wdata, 32'd0);
        check("midrst_rw", {27'd0, Wb_Rw}, 32'd0);
        check("midrst_regwr", {31'd0, Wb_RegWr}, 32'd0);
        check("midrst_mtr", {30'd0, Wb_MemtoReg}, 32'd0);
        rst = 1'b0;
        load("post_rst_lw", 32'h40, 3'b000, 32'hCAFE_F00D);

        // Address wrap
        store(32'h0, 32'h2222_2222, 3'b000);
        store(32'h1000, 32'h1111_1111, 3'b000);
        load("wrap_lw0", 32'h0, 3'b000, 32'h1111_1111);
        load("wrap_hi", 32'hFFFF_1000, 3'b000, 32'h1111_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
